// File: rtl/frontend_uop_queue.sv
// frontend_uop_queue: decoupling FIFO between decode and rename/dispatch.
// Holds decoded uops with their operand, PC and BHR fields, presents the head
// entry first-word-fall-through, raises a skid-aware stall to the frontend
// and discards all contents on a resteer flush.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. On the enqueue side enq_valid is the frontend's offer and the queue's
// ready is implicit (not full, or a dequeue in the same cycle). The frontend
// must honour stall_out within SKID uops. On the dequeue side deq_valid and
// the deq_* fields are stable once asserted until deq_ready takes the entry.
// Neither side's valid may depend combinationally on the other side's ready.
module frontend_uop_queue #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 8,
   parameter int SKID  = 2,
   parameter int UOP_W = 8,
   parameter int BHR_W = 10
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       enq_valid,
   input  logic [UOP_W-1:0]           enq_uop,
   input  logic                       enq_eoi,
   input  logic [4:0]                 enq_dr,
   input  logic [4:0]                 enq_sr1,
   input  logic [4:0]                 enq_sr2,
   input  logic [XLEN-1:0]            enq_imm,
   input  logic                       enq_use_imm,
   input  logic [XLEN-1:0]            enq_pc,
   input  logic                       enq_exception,
   input  logic [BHR_W-1:0]           enq_bhr,
   output logic                       stall_out,
   input  logic                       deq_ready,
   output logic                       deq_valid,
   output logic [UOP_W-1:0]           deq_uop,
   output logic                       deq_eoi,
   output logic [4:0]                 deq_dr,
   output logic [4:0]                 deq_sr1,
   output logic [4:0]                 deq_sr2,
   output logic [XLEN-1:0]            deq_imm,
   output logic                       deq_use_imm,
   output logic [XLEN-1:0]            deq_pc,
   output logic                       deq_exception,
   output logic [BHR_W-1:0]           deq_bhr,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = UOP_W + 1 + 5 + 5 + 5 + XLEN + 1 + XLEN + 1 + BHR_W;
   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(DEPTH - SKID);

   logic [ENT_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic             not_empty;
   logic             is_full;
   logic             deq_fire;
   logic             enq_fire;
   logic [ENT_W-1:0] wr_ent;
   logic [ENT_W-1:0] rd_ent;

   assign not_empty = (count != '0);
   assign is_full   = (count == FULL_CNT);

   // A flush hides the head immediately so rename never takes a squashed uop.
   assign deq_valid = not_empty & ~flush;
   assign deq_fire  = deq_valid & deq_ready;
   assign enq_fire  = enq_valid & (~is_full | deq_fire) & ~flush;
   assign stall_out = (count >= STALL_CNT);

   assign wr_ent = {enq_uop, enq_eoi, enq_dr, enq_sr1, enq_sr2, enq_imm,
                    enq_use_imm, enq_pc, enq_exception, enq_bhr};

   // Head fields are zeroed while empty so stale storage never leaks out.
   assign rd_ent = not_empty ? mem[head] : '0;
   assign {deq_uop, deq_eoi, deq_dr, deq_sr1, deq_sr2, deq_imm,
           deq_use_imm, deq_pc, deq_exception, deq_bhr} = rd_ent;

   // Storage write: payload only, no reset needed since count gates reads.
   always_ff @(posedge clk) begin
      if (enq_fire) begin
         mem[tail] <= wr_ent;
      end
   end

   // Pointer and occupancy update; flush returns the queue to empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (enq_fire) begin
            tail <= tail + PTR_W'(1);
         end
         if (deq_fire) begin
            head <= head + PTR_W'(1);
         end
         count <= count + {{PTR_W{1'b0}}, enq_fire} - {{PTR_W{1'b0}}, deq_fire};
      end
   end

   // Sticky drop flag: an offered uop lost because the queue was full.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if (enq_valid & is_full & ~deq_fire & ~flush) begin
         overflow <= 1'b1;
      end
   end

endmodule
